// File: rtl/qec_pe_pkg.sv
// qec_pe_pkg: shared stage encoding and root-key helper for the union-find PE array
package qec_pe_pkg;
  localparam int STAGE_WIDTH = 3;
  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE                = 3'd0,
    STAGE_MEASUREMENT_LOADING = 3'd1,
    STAGE_GROW                = 3'd2,
    STAGE_MERGE               = 3'd3,
    STAGE_PEELING             = 3'd4,
    STAGE_RESULT_VALID        = 3'd5
  } stage_e;
  function automatic logic [31:0] root_key(input logic anchored, input logic [31:0] addr, input int aw);
    return (32'(!anchored) << aw) | addr;
  endfunction
endpackage

// File: rtl/processing_unit_v3_if.sv
// processing_unit_v3_if: controller and neighbour-facing signals of one PE
interface processing_unit_v3_if import qec_pe_pkg::*; #(
  parameter int NEIGHBOR_COUNT = 6,
  parameter int ROOT_WIDTH = 10
);
  logic measurement;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic [NEIGHBOR_COUNT-1:0] neighbor_fully_grown;
  logic [NEIGHBOR_COUNT*ROOT_WIDTH-1:0] neighbor_root;
  logic [NEIGHBOR_COUNT-1:0] neighbor_parent_vector;
  logic [NEIGHBOR_COUNT-1:0] child_cluster_parity;
  logic [NEIGHBOR_COUNT-1:0] parent_odd;
  logic neighbor_increase;
  logic [NEIGHBOR_COUNT-1:0] parent_vector;
  logic [ROOT_WIDTH-1:0] root;
  logic cluster_parity;
  logic odd;
  logic boundary_reached;
  logic busy;
  logic [NEIGHBOR_COUNT-1:0] correction_vector;
  logic correction_boundary;
  modport master (
    input measurement, global_stage, neighbor_fully_grown, neighbor_root,
          neighbor_parent_vector, child_cluster_parity, parent_odd,
    output neighbor_increase, parent_vector, root, cluster_parity, odd,
           boundary_reached, busy, correction_vector, correction_boundary
  );
  modport slave (
    output measurement, global_stage, neighbor_fully_grown, neighbor_root,
           neighbor_parent_vector, child_cluster_parity, parent_odd,
    input neighbor_increase, parent_vector, root, cluster_parity, odd,
          boundary_reached, busy, correction_vector, correction_boundary
  );
endinterface

// File: rtl/min_index_tree.sv
// min_index_tree: minimum over valid lanes with a one-hot of the lowest-index winner
module min_index_tree #(
  parameter int DATA_WIDTH = 10,
  parameter int CHANNEL_COUNT = 6
)(
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] data,
  input  logic [CHANNEL_COUNT-1:0] valid,
  output logic [DATA_WIDTH-1:0] min_value,
  output logic [CHANNEL_COUNT-1:0] min_onehot,
  output logic any_valid
);
  // strict less-than keeps the earliest lane on ties
  always_comb begin
    min_value = '1;
    min_onehot = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      if (valid[i] && (min_onehot == '0 || data[i*DATA_WIDTH +: DATA_WIDTH] < min_value)) begin
        min_value = data[i*DATA_WIDTH +: DATA_WIDTH];
        min_onehot = CHANNEL_COUNT'(1) << i;
      end
  end
  assign any_valid = |valid;
endmodule

// File: rtl/processing_unit_v3.sv
// processing_unit_v3: union-find PE with weighted boundary growth and peeling output
module processing_unit_v3 import qec_pe_pkg::*; #(
  parameter int NEIGHBOR_COUNT = 6,
  parameter int PER_DIM_BIT_WIDTH = 3,
  parameter int ADDRESS_WIDTH = 3*PER_DIM_BIT_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] ADDRESS = '0,
  parameter int BW_WIDTH = 4,
  parameter logic [BW_WIDTH-1:0] BOUNDARY_WEIGHT = '0,
  parameter int ROOT_WIDTH = ADDRESS_WIDTH+1
)(
  input logic clk,
  input logic reset,
  processing_unit_v3_if.master bus
);
  stage_e stage, last_stage;
  logic m;
  logic [BW_WIDTH-1:0] boundary_count, count_n;
  logic [ROOT_WIDTH-1:0] root, root_m, own_key, home_key, cand;
  logic [NEIGHBOR_COUNT-1:0] parent_vector, pv_m, cand_onehot, correction_vector;
  logic cluster_parity, odd, boundary_reached, busy, correction_boundary;
  logic any_valid, take_cand, take_own, parity_m, odd_m, busy_m, reached_n;
  logic entry_grow, entry_peel;
  min_index_tree #(.DATA_WIDTH(ROOT_WIDTH), .CHANNEL_COUNT(NEIGHBOR_COUNT)) u_min (
    .data(bus.neighbor_root),
    .valid(bus.neighbor_fully_grown),
    .min_value(cand),
    .min_onehot(cand_onehot),
    .any_valid(any_valid)
  );
  assign home_key = ROOT_WIDTH'(root_key(1'b0, 32'(ADDRESS), ADDRESS_WIDTH));
  assign own_key = ROOT_WIDTH'(root_key(boundary_reached, 32'(ADDRESS), ADDRESS_WIDTH));
  assign entry_grow = stage == STAGE_GROW && last_stage != STAGE_GROW;
  assign entry_peel = stage == STAGE_PEELING && last_stage != STAGE_PEELING;
  // boundary growth: one step per GROW entry while odd, cleared on load
  always_comb begin
    count_n = stage == STAGE_MEASUREMENT_LOADING ? '0 :
              (entry_grow && odd && boundary_count < BOUNDARY_WEIGHT) ? boundary_count + 1'b1 : boundary_count;
    reached_n = BOUNDARY_WEIGHT != '0 && count_n == BOUNDARY_WEIGHT;
  end
  // merge candidate: adopt a smaller neighbour root, else re-root onto own boundary anchor
  always_comb begin
    take_cand = any_valid && cand < root;
    take_own = !take_cand && own_key < root;
    root_m = take_cand ? cand : take_own ? own_key : root;
    pv_m = take_cand ? cand_onehot : take_own ? '0 : parent_vector;
    parity_m = ^(bus.neighbor_parent_vector & bus.child_cluster_parity) ^ m;
    odd_m = |pv_m ? |(pv_m & bus.parent_odd) : parity_m & root_m[ROOT_WIDTH-1];
    busy_m = root_m != root || pv_m != parent_vector || parity_m != cluster_parity || odd_m != odd;
  end
  // stage tracking and per-stage register updates
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= STAGE_IDLE;
      last_stage <= STAGE_IDLE;
      m <= 1'b0;
      boundary_count <= '0;
      boundary_reached <= 1'b0;
      root <= home_key;
      parent_vector <= '0;
      cluster_parity <= 1'b0;
      odd <= 1'b0;
      busy <= 1'b0;
      correction_vector <= '0;
      correction_boundary <= 1'b0;
    end else begin
      stage <= stage_e'(bus.global_stage);
      last_stage <= stage;
      boundary_count <= count_n;
      boundary_reached <= reached_n;
      if (stage == STAGE_MEASUREMENT_LOADING) begin
        m <= bus.measurement;
        cluster_parity <= bus.measurement;
        odd <= bus.measurement;
        root <= home_key;
        parent_vector <= '0;
        busy <= 1'b0;
        correction_vector <= '0;
        correction_boundary <= 1'b0;
      end else if (stage == STAGE_MERGE) begin
        root <= root_m;
        parent_vector <= pv_m;
        cluster_parity <= parity_m;
        odd <= odd_m;
        busy <= busy_m;
      end else if (entry_peel) begin
        correction_vector <= cluster_parity ? parent_vector : '0;
        correction_boundary <= cluster_parity && parent_vector == '0 && boundary_reached;
      end
    end
  end
  assign bus.neighbor_increase = odd && entry_grow;
  assign bus.parent_vector = parent_vector;
  assign bus.root = root;
  assign bus.cluster_parity = cluster_parity;
  assign bus.odd = odd;
  assign bus.boundary_reached = boundary_reached;
  assign bus.busy = busy;
  assign bus.correction_vector = correction_vector;
  assign bus.correction_boundary = correction_boundary;
endmodule

// File: tb/tb_processing_unit_v3.sv
// tb_processing_unit_v3: scoreboard bench for two PEs (no boundary and weight-2 boundary)
module tb_processing_unit_v3;
  import qec_pe_pkg::*;
  localparam int N = 6;
  localparam int RW = 10;
  localparam int ADDR = 7;
  localparam int HOME = 512 + ADDR;
  typedef struct packed {
    logic [RW-1:0] root;
    logic [N-1:0] pv;
    logic par, odd, br, busy;
    logic [N-1:0] cv;
    logic cb, ni;
  } exp_t;
  typedef struct {
    int m, root, pv, par, odd, bc, br, busy, cv, cb, stage, last;
  } ms_t;
  logic clk = 0, rst = 1, meas = 0;
  logic [STAGE_WIDTH-1:0] gs = '0;
  logic [N-1:0] fg = '0, npv = '0, ccp = '0, po = '0;
  logic [N*RW-1:0] nr = '0;
  int errors = 0, checks = 0;
  exp_t q0[$], q1[$];
  ms_t ms[2];
  exp_t a0, a1;
  always #5 clk = ~clk;
  processing_unit_v3_if #(.NEIGHBOR_COUNT(N), .ROOT_WIDTH(RW)) bus0();
  processing_unit_v3_if #(.NEIGHBOR_COUNT(N), .ROOT_WIDTH(RW)) bus2();
  assign bus0.measurement = meas;
  assign bus0.global_stage = gs;
  assign bus0.neighbor_fully_grown = fg;
  assign bus0.neighbor_root = nr;
  assign bus0.neighbor_parent_vector = npv;
  assign bus0.child_cluster_parity = ccp;
  assign bus0.parent_odd = po;
  assign bus2.measurement = meas;
  assign bus2.global_stage = gs;
  assign bus2.neighbor_fully_grown = fg;
  assign bus2.neighbor_root = nr;
  assign bus2.neighbor_parent_vector = npv;
  assign bus2.child_cluster_parity = ccp;
  assign bus2.parent_odd = po;
  processing_unit_v3 #(.ADDRESS(9'(ADDR)), .BOUNDARY_WEIGHT(4'd0)) dut0 (.clk(clk), .reset(rst), .bus(bus0.master));
  processing_unit_v3 #(.ADDRESS(9'(ADDR)), .BOUNDARY_WEIGHT(4'd2)) dut2 (.clk(clk), .reset(rst), .bus(bus2.master));
  assign a0 = {bus0.root, bus0.parent_vector, bus0.cluster_parity, bus0.odd, bus0.boundary_reached,
               bus0.busy, bus0.correction_vector, bus0.correction_boundary, bus0.neighbor_increase};
  assign a1 = {bus2.root, bus2.parent_vector, bus2.cluster_parity, bus2.odd, bus2.boundary_reached,
               bus2.busy, bus2.correction_vector, bus2.correction_boundary, bus2.neighbor_increase};
  // behavioural PE: what one clock does to a PE given the stage it is in
  function automatic ms_t step(ms_t s, int bw);
    ms_t n;
    int own, best, lane;
    bit ent;
    n = s;
    if (rst) begin
      n = '{default: 0};
      n.root = HOME;
      return n;
    end
    n.stage = int'(gs);
    n.last = s.stage;
    ent = s.stage != s.last;
    if (s.stage == 1) begin
      n.m = meas; n.par = meas; n.odd = meas; n.root = HOME; n.pv = 0;
      n.bc = 0; n.br = 0; n.busy = 0; n.cv = 0; n.cb = 0;
    end else if (s.stage == 2) begin
      if (ent && s.odd != 0 && s.bc < bw) n.bc = s.bc + 1;
      n.br = (bw != 0 && n.bc == bw) ? 1 : 0;
    end else if (s.stage == 3) begin
      own = (s.br != 0 ? 0 : 512) + ADDR;
      best = -1;
      lane = 0;
      for (int i = 0; i < N; i++)
        if (fg[i] && (best < 0 || int'(nr[i*RW +: RW]) < best)) begin
          best = int'(nr[i*RW +: RW]);
          lane = i;
        end
      if (best >= 0 && best < s.root) begin n.root = best; n.pv = 1 << lane; end
      else if (own < s.root) begin n.root = own; n.pv = 0; end
      n.par = ($countones(npv & ccp) + s.m) % 2;
      n.odd = n.pv != 0 ? (((n.pv & int'(po)) != 0) ? 1 : 0) : ((n.par == 1 && n.root >= 512) ? 1 : 0);
      n.busy = (n.root != s.root || n.pv != s.pv || n.par != s.par || n.odd != s.odd) ? 1 : 0;
    end else if (s.stage == 4 && ent) begin
      n.cv = s.par != 0 ? s.pv : 0;
      n.cb = (s.par != 0 && s.pv == 0 && s.br != 0) ? 1 : 0;
    end
    return n;
  endfunction
  function automatic exp_t to_exp(ms_t s);
    exp_t e;
    e.root = RW'(s.root); e.pv = N'(s.pv); e.par = s.par[0]; e.odd = s.odd[0];
    e.br = s.br[0]; e.busy = s.busy[0]; e.cv = N'(s.cv); e.cb = s.cb[0];
    e.ni = s.odd != 0 && s.stage == 2 && s.last != 2;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask
  task automatic cmp(input string d, input exp_t a, input exp_t e);
    chk({d, ".root"}, 32'(a.root), 32'(e.root));
    chk({d, ".parent_vector"}, 32'(a.pv), 32'(e.pv));
    chk({d, ".cluster_parity"}, 32'(a.par), 32'(e.par));
    chk({d, ".odd"}, 32'(a.odd), 32'(e.odd));
    chk({d, ".boundary_reached"}, 32'(a.br), 32'(e.br));
    chk({d, ".busy"}, 32'(a.busy), 32'(e.busy));
    chk({d, ".correction_vector"}, 32'(a.cv), 32'(e.cv));
    chk({d, ".correction_boundary"}, 32'(a.cb), 32'(e.cb));
    chk({d, ".neighbor_increase"}, 32'(a.ni), 32'(e.ni));
  endtask
  // drive one cycle: predict both PEs, queue expectations, advance the clock
  task automatic tick(input int stg, input bit r);
    gs = STAGE_WIDTH'(stg);
    rst = r;
    ms[0] = step(ms[0], 0);
    ms[1] = step(ms[1], 2);
    q0.push_back(to_exp(ms[0]));
    q1.push_back(to_exp(ms[1]));
    @(posedge clk);
    #2;
  endtask
  task automatic run(input int stg, input int cycles);
    for (int c = 0; c < cycles; c++) tick(stg, 1'b0);
  endtask
  task automatic clear_nb();
    fg = '0; nr = '0; npv = '0; ccp = '0; po = '0;
  endtask
  // monitor: compare each presented output set against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); cmp("pe_bw0", a0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); cmp("pe_bw2", a1, e); end
    end
  end
  initial begin
    ms[0] = '{default: 0};
    ms[1] = '{default: 0};
    tick(0, 1); tick(0, 1); tick(0, 0);
    meas = 1; run(1, 2);
    run(2, 3); run(0, 1);
    run(2, 2); run(0, 1);
    run(3, 2);
    fg = 6'b010100;
    nr[2*RW +: RW] = 10'h005;
    nr[4*RW +: RW] = 10'h005;
    run(3, 3);
    run(4, 2); run(5, 2);
    clear_nb(); meas = 0; run(1, 2);
    npv = 6'b000011; ccp = 6'b000001;
    run(3, 3); run(4, 2); run(5, 1);
    clear_nb(); meas = 1; run(1, 2);
    fg = 6'b010000; nr[4*RW +: RW] = 10'h003;
    run(3, 3); run(4, 2); run(5, 3);
    clear_nb(); run(1, 2);
    fg = 6'b000001; nr[RW-1:0] = 10'h002;
    run(3, 2);
    tick(3, 1);
    run(3, 2); run(4, 2);
    tick(4, 1);
    run(5, 2);
    for (int r = 0; r < 40; r++) begin
      clear_nb();
      meas = 1'($urandom);
      run(1, $urandom_range(1, 2));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        run(2, $urandom_range(1, 3));
        run(0, 1);
      end
      for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
        fg = N'($urandom);
        for (int i = 0; i < N; i++) nr[i*RW +: RW] = RW'($urandom_range(0, 1023));
        npv = N'($urandom); ccp = N'($urandom); po = N'($urandom);
        tick(3, $urandom_range(0, 19) == 0);
      end
      run(4, $urandom_range(1, 2));
      run(5, $urandom_range(1, 2));
    end
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
